// File: rtl/pmod_jstk_spi_if.sv
// SPI link between the joystick reader (master) and a PmodJSTK (slave).
interface pmod_jstk_spi_if;
  logic sclk;
  logic mosi;
  logic miso;
  logic ss_n;

  modport master (
    output sclk,
    output mosi,
    output ss_n,
    input  miso
  );

  modport slave (
    input  sclk,
    input  mosi,
    input  ss_n,
    output miso
  );
endinterface

// File: rtl/pmod_jstk_spi_reader.sv
// Periodic SPI mode-0 poller for a PmodJSTK: reads 5-byte frames, drives the LEDs and
// publishes X/Y/buttons plus the thresholded {button, Y-high, X-high} axis vector.
module pmod_jstk_spi_reader #(
  parameter int unsigned ClkDiv     = 100,
  parameter int unsigned SsSetup    = 1500,
  parameter int unsigned ByteGap    = 1000,
  parameter int unsigned PollPeriod = 1000000,
  parameter int unsigned XThresh    = 768,
  parameter int unsigned YThresh    = 768
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  input  logic [1:0]             leds_i,
  pmod_jstk_spi_if.master        spi,
  output logic [9:0]             x_pos_o,
  output logic [9:0]             y_pos_o,
  output logic [2:0]             buttons_o,
  output logic [2:0]             jstk_axis_o,
  output logic                   sample_valid_o,
  output logic                   busy_o
);

  localparam int unsigned WaitMax = (SsSetup > ByteGap) ?
                                    ((SsSetup > ClkDiv) ? SsSetup : ClkDiv) :
                                    ((ByteGap > ClkDiv) ? ByteGap : ClkDiv);
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);
  localparam int unsigned PollW   = $clog2(PollPeriod);

  localparam logic [WaitW-1:0] SetupLast = WaitW'(SsSetup - 1);
  localparam logic [WaitW-1:0] GapLast   = WaitW'(ByteGap - 1);
  localparam logic [WaitW-1:0] DivLast   = WaitW'(ClkDiv - 1);
  localparam logic [PollW-1:0] PollLast  = PollW'(PollPeriod - 1);
  localparam logic [9:0]       XThr      = 10'(XThresh);
  localparam logic [9:0]       YThr      = 10'(YThresh);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StGap, StDone} state_e;

  state_e           state_q;
  logic [PollW-1:0] poll_q;
  logic [WaitW-1:0] wait_q;
  logic [2:0]       bit_q;
  logic [2:0]       byte_q;
  logic             first_q;
  logic [1:0]       leds_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_q;
  logic [7:0]       x_lo_q;
  logic [1:0]       x_hi_q;
  logic [7:0]       y_lo_q;
  logic [1:0]       y_hi_q;
  logic             sclk_q;
  logic             ss_n_q;
  logic             busy_q;
  logic             sample_valid_q;
  logic [9:0]       x_pos_q;
  logic [9:0]       y_pos_q;
  logic [2:0]       buttons_q;
  logic [2:0]       jstk_axis_q;

  logic [9:0] x_full;
  logic [9:0] y_full;
  assign x_full = {x_hi_q, x_lo_q};
  assign y_full = {y_hi_q, y_lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      poll_q         <= '0;
      wait_q         <= '0;
      bit_q          <= 3'd0;
      byte_q         <= 3'd0;
      first_q        <= 1'b1;
      leds_q         <= 2'b00;
      tx_q           <= 8'h00;
      rx_q           <= 8'h00;
      x_lo_q         <= 8'h00;
      x_hi_q         <= 2'b00;
      y_lo_q         <= 8'h00;
      y_hi_q         <= 2'b00;
      sclk_q         <= 1'b0;
      ss_n_q         <= 1'b1;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      x_pos_q        <= 10'd0;
      y_pos_q        <= 10'd0;
      buttons_q      <= 3'b000;
      jstk_axis_q    <= 3'b000;
    end else begin
      sample_valid_q <= 1'b0;

      // Poll counter spans the whole frame so starts are PollPeriod apart.
      if (!enable_i) begin
        poll_q <= '0;
      end else if (poll_q != PollLast) begin
        poll_q <= poll_q + PollW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (enable_i && (first_q || (poll_q == PollLast))) begin
            state_q <= StSetup;
            poll_q  <= '0;
            first_q <= 1'b0;
            ss_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            leds_q  <= leds_i;
            wait_q  <= '0;
            byte_q  <= 3'd0;
          end
        end

        StSetup: begin
          if (wait_q == SetupLast) begin
            state_q <= StShift;
            wait_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= {6'b100000, leds_q};
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end

        StShift: begin
          if (wait_q == DivLast) begin
            wait_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[6:0], spi.miso};
            end else begin
              sclk_q <= 1'b0;
              if (bit_q != 3'd7) begin
                bit_q <= bit_q + 3'd1;
                tx_q  <= {tx_q[6:0], 1'b0};
              end else begin
                bit_q <= 3'd0;
                tx_q  <= 8'h00;
                unique case (byte_q)
                  3'd0:    x_lo_q <= rx_q;
                  3'd1:    x_hi_q <= rx_q[1:0];
                  3'd2:    y_lo_q <= rx_q;
                  3'd3:    y_hi_q <= rx_q[1:0];
                  default: ;
                endcase
                if (byte_q == 3'd4) begin
                  // Whole frame received: publish everything in one edge.
                  state_q        <= StDone;
                  ss_n_q         <= 1'b1;
                  busy_q         <= 1'b0;
                  sample_valid_q <= 1'b1;
                  x_pos_q        <= x_full;
                  y_pos_q        <= y_full;
                  buttons_q      <= rx_q[2:0];
                  jstk_axis_q    <= {rx_q[0], (y_full > YThr), (x_full > XThr)};
                end else begin
                  state_q <= StGap;
                  byte_q  <= byte_q + 3'd1;
                end
              end
            end
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end

        StGap: begin
          if (wait_q == GapLast) begin
            state_q <= StShift;
            wait_q  <= '0;
            tx_q    <= 8'h00;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign spi.sclk       = sclk_q;
  assign spi.mosi       = tx_q[7];
  assign spi.ss_n       = ss_n_q;
  assign x_pos_o        = x_pos_q;
  assign y_pos_o        = y_pos_q;
  assign buttons_o      = buttons_q;
  assign jstk_axis_o    = jstk_axis_q;
  assign sample_valid_o = sample_valid_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_pmod_jstk_spi_reader.sv
// Bench for pmod_jstk_spi_reader: behavioural PmodJSTK slave, vector table and corner sequences.
module tb_pmod_jstk_spi_reader;

  localparam int unsigned ClkDiv     = 2;
  localparam int unsigned SsSetup    = 4;
  localparam int unsigned ByteGap    = 3;
  localparam int unsigned PollPeriod = 200;
  localparam int unsigned XThresh    = 768;
  localparam int unsigned YThresh    = 768;
  localparam int unsigned FrameLow   = SsSetup + 5 * 16 * ClkDiv + 4 * ByteGap;
  localparam int          NumVec     = 13;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] btn;
    logic [1:0] leds;
    logic [2:0] axis;
  } vec_t;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] leds   = 2'b00;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [2:0] buttons;
  logic [2:0] axis;
  logic       sv;
  logic       busy;

  pmod_jstk_spi_if spi ();

  pmod_jstk_spi_reader #(
    .ClkDiv    (ClkDiv),
    .SsSetup   (SsSetup),
    .ByteGap   (ByteGap),
    .PollPeriod(PollPeriod),
    .XThresh   (XThresh),
    .YThresh   (YThresh)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable),
    .leds_i        (leds),
    .spi           (spi),
    .x_pos_o       (x_pos),
    .y_pos_o       (y_pos),
    .buttons_o     (buttons),
    .jstk_axis_o   (axis),
    .sample_valid_o(sv),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // Slave: loads its 40-bit reply on ss_n fall, shifts out on sclk fall, captures mosi on rise.
  logic [9:0]  sl_x   = 10'd0;
  logic [9:0]  sl_y   = 10'd0;
  logic [2:0]  sl_btn = 3'd0;
  logic [39:0] slave_sr = '0;
  logic [39:0] mosi_cap = '0;
  logic [31:0] junk;
  logic        active = 1'b0;
  int          rise_cnt = 0;

  assign spi.miso = slave_sr[39];

  always @(posedge spi.ss_n or negedge spi.ss_n or posedge spi.sclk or negedge spi.sclk) begin
    if (spi.ss_n !== 1'b0) begin
      active = 1'b0;
    end else if (!active) begin
      active   = 1'b1;
      rise_cnt = 0;
      mosi_cap = '0;
      junk     = $urandom;
      slave_sr = {sl_x[7:0], junk[5:0], sl_x[9:8], sl_y[7:0], junk[11:6], sl_y[9:8],
                  junk[16:12], sl_btn};
    end else if (spi.sclk === 1'b1) begin
      mosi_cap = {mosi_cap[38:0], spi.mosi};
      rise_cnt++;
    end else begin
      slave_sr = {slave_sr[38:0], 1'b0};
    end
  end

  int   cyc        = 0;
  int   low_cnt    = 0;
  int   start_gap  = 0;
  int   last_start = 0;
  logic prev_ss    = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (spi.ss_n === 1'b0) begin
      if (prev_ss) begin
        start_gap  = cyc - last_start;
        last_start = cyc;
        low_cnt    = 0;
      end
      low_cnt++;
    end
    prev_ss = (spi.ss_n !== 1'b0);
  end

  int sclk_bad = 0;
  always @(posedge spi.sclk) if (rst_n && spi.ss_n === 1'b1) sclk_bad++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] model_axis(input logic [9:0] x, input logic [9:0] y,
                                            input logic [2:0] b);
    logic xb;
    logic yb;
    xb = (int'(x) > int'(XThresh));
    yb = (int'(y) > int'(YThresh));
    return {b[0], yb, xb};
  endfunction

  task automatic wait_sv(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (sv === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rise(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (spi.ss_n === 1'b0 && rise_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_slave(input vec_t v);
    sl_x   = v.x;
    sl_y   = v.y;
    sl_btn = v.btn;
    leds   = v.leds;
  endtask

  // Called on the sample_valid cycle.
  task automatic check_frame(input vec_t v, input string tag);
    logic [39:0] exp_mosi;
    exp_mosi = {6'b100000, v.leds, 32'h0};
    chk({tag, "_x"},    64'(x_pos),    64'(v.x));
    chk({tag, "_y"},    64'(y_pos),    64'(v.y));
    chk({tag, "_btn"},  64'(buttons),  64'(v.btn));
    chk({tag, "_axis"}, 64'(axis),     64'(v.axis));
    chk({tag, "_mosi"}, 64'(mosi_cap), 64'(exp_mosi));
    chk({tag, "_bits"}, 64'(rise_cnt), 64'd40);
    chk({tag, "_len"},  64'(low_cnt),  64'(FrameLow));
    chk({tag, "_ssn"},  64'(spi.ss_n), 64'd1);
    chk({tag, "_busy"}, 64'(busy),     64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(sv), 64'd0);
  endtask

  vec_t vecs [NumVec];
  vec_t va;
  vec_t vb;
  vec_t vc;
  bit   ok;
  int   lows;
  int   lat;

  initial begin
    vecs[0] = '{x: 10'h3FF, y: 10'h000, btn: 3'b001, leds: 2'b10, axis: 3'b101};
    vecs[1] = '{x: 10'd768, y: 10'd769, btn: 3'b000, leds: 2'b01, axis: 3'b010};
    vecs[2] = '{x: 10'd769, y: 10'd768, btn: 3'b001, leds: 2'b11, axis: 3'b101};
    vecs[3] = '{x: 10'd0,   y: 10'd0,   btn: 3'b110, leds: 2'b00, axis: 3'b000};
    vecs[4] = '{x: 10'd767, y: 10'd1023, btn: 3'b111, leds: 2'b01, axis: 3'b110};
    for (int i = 5; i < NumVec; i++) begin
      if (i % 2 == 0) begin
        vecs[i].x = 10'(766 + $urandom_range(0, 4));
        vecs[i].y = 10'(766 + $urandom_range(0, 4));
      end else begin
        vecs[i].x = 10'($urandom);
        vecs[i].y = 10'($urandom);
      end
      vecs[i].btn  = 3'($urandom);
      vecs[i].leds = 2'($urandom);
      vecs[i].axis = model_axis(vecs[i].x, vecs[i].y, vecs[i].btn);
    end

    load_slave(vecs[0]);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ssn",  64'(spi.ss_n), 64'd1);
    chk("rst_sclk", 64'(spi.sclk), 64'd0);
    chk("rst_mosi", 64'(spi.mosi), 64'd0);
    chk("rst_busy", 64'(busy),     64'd0);
    chk("rst_x",    64'(x_pos),    64'd0);
    chk("rst_y",    64'(y_pos),    64'd0);
    chk("rst_btn",  64'(buttons),  64'd0);
    chk("rst_axis", 64'(axis),     64'd0);
    chk("rst_sv",   64'(sv),       64'd0);

    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("start_busy", 64'(busy),     64'd1);
    chk("start_ssn",  64'(spi.ss_n), 64'd0);

    for (int i = 0; i < NumVec; i++) begin
      wait_sv(ok);
      chk($sformatf("v%0d_sv_seen", i), 64'(ok), 64'd1);
      if (i > 0) chk($sformatf("v%0d_period", i), 64'(start_gap), 64'(PollPeriod));
      check_frame(vecs[i], $sformatf("v%0d", i));
      if (i < NumVec - 1) begin
        load_slave(vecs[i + 1]);
        wait_rise(20, ok);
        chk($sformatf("v%0d_next_start", i), 64'(ok), 64'd1);
        // Mid-frame: old result must hold and an LED change must not leak in.
        leds = ~leds;
        chk($sformatf("v%0d_hold_x", i), 64'(x_pos), 64'(vecs[i].x));
        chk($sformatf("v%0d_hold_axis", i), 64'(axis), 64'(vecs[i].axis));
      end
    end

    // Reset during byte 2, then a fresh frame with different data.
    va = '{x: 10'h155, y: 10'h2AA, btn: 3'b010, leds: 2'b01, axis: 3'b000};
    vb = '{x: 10'h301, y: 10'h0F0, btn: 3'b101, leds: 2'b11, axis: 3'b000};
    va.axis = model_axis(va.x, va.y, va.btn);
    vb.axis = model_axis(vb.x, vb.y, vb.btn);
    load_slave(va);
    wait_rise(20, ok);
    chk("mr_reach_byte2", 64'(ok), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_ssn",  64'(spi.ss_n), 64'd1);
    chk("mr_sclk", 64'(spi.sclk), 64'd0);
    chk("mr_busy", 64'(busy),     64'd0);
    chk("mr_x",    64'(x_pos),    64'd0);
    chk("mr_y",    64'(y_pos),    64'd0);
    chk("mr_axis", 64'(axis),     64'd0);
    @(negedge clk);
    load_slave(vb);
    rst_n = 1'b1;
    wait_sv(ok);
    chk("mr_sv_seen", 64'(ok), 64'd1);
    check_frame(vb, "mr_fresh");

    // Enable dropped during byte 1: frame completes, then the bus stays idle.
    vc = '{x: 10'h320, y: 10'h3FE, btn: 3'b011, leds: 2'b10, axis: 3'b000};
    vc.axis = model_axis(vc.x, vc.y, vc.btn);
    load_slave(vc);
    wait_rise(10, ok);
    chk("dis_reach_byte1", 64'(ok), 64'd1);
    enable = 1'b0;
    wait_sv(ok);
    chk("dis_sv_seen", 64'(ok), 64'd1);
    check_frame(vc, "dis");
    lows = 0;
    repeat (3 * PollPeriod + 20) begin
      @(negedge clk);
      if (spi.ss_n !== 1'b1) lows++;
    end
    chk("dis_idle", 64'(lows), 64'd0);

    // Re-enable: next frame one full poll period later.
    enable = 1'b1;
    lat = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      lat++;
      if (spi.ss_n === 1'b0) break;
    end
    chk("reen_latency", 64'(lat), 64'(PollPeriod));

    chk("sclk_quiet_when_deselected", 64'(sclk_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
